// File: rtl/timer_ctrl.sv
// timer_ctrl: prescaled down-counter timer with one-shot/periodic modes,
// sticky interrupt flag and abort. State sequence IDLE -> LOAD -> RUN ->
// EXPIRE, with EXPIRE returning to LOAD (periodic) or IDLE (one-shot).
module timer_ctrl #(
   parameter int DW = 32,
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          start,
   input  logic          stop,
   input  logic          periodic,
   input  logic [DW-1:0] period,
   input  logic [PW-1:0] prescale,
   input  logic          irq_clear,
   output logic [DW-1:0] count,
   output logic          busy,
   output logic          expired,
   output logic          irq,
   output logic [1:0]    state
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;
   localparam logic [1:0] ST_EXPIRE = 2'd3;

   localparam logic [DW-1:0] CNT_ONE   = DW'(1);
   localparam logic [PW-1:0] PRESC_ONE = PW'(1);

   logic [1:0]    state_reg, state_next;
   logic [DW-1:0] count_reg, count_next;
   logic [PW-1:0] presc_reg, presc_next;
   logic          irq_reg, irq_next;

   // Next-state, counter and prescaler logic; stop overrides everything and
   // leaves count/prescaler untouched.
   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      presc_next = presc_reg;
      if (stop) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
               count_next = period;
               presc_next = '0;
               state_next = (period == '0) ? ST_EXPIRE : ST_RUN;
            end
            ST_RUN: begin
               // prescale is compared live so a host may retune the tick rate
               // mid-run; period only matters at the next LOAD.
               if (presc_reg == prescale) begin
                  presc_next = '0;
                  // <= 1 rather than == 1 keeps count from ever wrapping.
                  if (count_reg <= CNT_ONE) begin
                     count_next = '0;
                     state_next = ST_EXPIRE;
                  end else begin
                     count_next = count_reg - CNT_ONE;
                  end
               end else begin
                  presc_next = presc_reg + PRESC_ONE;
               end
            end
            ST_EXPIRE: begin
               state_next = periodic ? ST_LOAD : ST_IDLE;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // Sticky interrupt: an expiry (not aborted by stop) beats a coincident clear.
   always_comb begin
      irq_next = irq_reg;
      if ((state_reg == ST_EXPIRE) && !stop) begin
         irq_next = 1'b1;
      end else if (irq_clear) begin
         irq_next = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_reg <= ST_IDLE;
         count_reg <= '0;
         presc_reg <= '0;
         irq_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         presc_reg <= presc_next;
         irq_reg   <= irq_next;
      end
   end

   assign state   = state_reg;
   assign count   = count_reg;
   assign irq     = irq_reg;
   assign busy    = (state_reg != ST_IDLE);
   assign expired = (state_reg == ST_EXPIRE);

endmodule
